// File: rtl/bcd_display_mux.sv
// Purpose: time-multiplexed 3-digit 7-segment driver with double-buffered BCD value, leading-zero blanking and per-digit dp.
// Latency: an/sseg are registered and show the next digit one clk after the prescaler tick; a load is shown from the next frame.
// Backpressure: none; load is always accepted (last load wins) and en=0 darkens the display while holding the scan position.
module bcd_display_mux #(
    parameter int CLK_DIV  = 50000,
    parameter bit BLANK_LZ = 1'b1,
    parameter bit SEG_ALOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] bcd_in,
    input  logic [2:0]  dp_in,
    input  logic        load,
    input  logic        en,
    output logic [2:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_done
);

    localparam int            PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP  = PW'(CLK_DIV - 1);
    // Value driven on sseg when every segment is off, in output polarity.
    localparam logic [7:0]    SEG_OFF  = SEG_ALOW ? 8'hFF : 8'h00;

    // Buffer word layout: {dp[2:0] = {h,t,u}, hundreds, tens, units}.
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [14:0]   pending;
    logic          pend_vld;
    logic [14:0]   active;

    logic          tick;
    logic          wrap;
    logic [1:0]    idx_nxt;
    logic [14:0]   active_nxt;
    logic [2:0]    an_nxt;
    logic [7:0]    seg_hi;

    // Standard active-high glyphs {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Scan timing: tick ends each digit slot, wrap ends the frame (hundreds -> units).
    always_comb begin
        tick    = en && (presc == PRE_TOP);
        wrap    = tick && (idx == 2'd2);
        idx_nxt = idx;
        if (tick) begin
            idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

    // Next active value: a load coinciding with the wrap bypasses the pending buffer.
    always_comb begin
        active_nxt = active;
        if (wrap) begin
            if (load) begin
                active_nxt = {dp_in, bcd_in};
            end else if (pend_vld) begin
                active_nxt = pending;
            end
        end
    end

    // Decode the digit that will be lit next cycle, from the next-state index and buffer.
    always_comb begin
        logic [3:0] dig;
        logic       dp_bit;
        logic       h_zero;
        logic       t_zero;
        logic       blank;
        dig    = 4'd0;
        dp_bit = 1'b0;
        an_nxt = 3'b111;
        h_zero = (active_nxt[11:8] == 4'd0);
        t_zero = (active_nxt[7:4] == 4'd0);
        case (idx_nxt)
            2'd0: begin
                dig    = active_nxt[3:0];
                dp_bit = active_nxt[12];
                an_nxt = 3'b110;
            end
            2'd1: begin
                dig    = active_nxt[7:4];
                dp_bit = active_nxt[13];
                an_nxt = 3'b101;
            end
            default: begin
                dig    = active_nxt[11:8];
                dp_bit = active_nxt[14];
                an_nxt = 3'b011;
            end
        endcase
        // Units is never blanked so a value of zero still shows "0".
        blank = BLANK_LZ && (((idx_nxt == 2'd2) && h_zero) ||
                             ((idx_nxt == 2'd1) && h_zero && t_zero));
        seg_hi = blank ? 8'h00 : {dp_bit, seg7(dig)};
    end

    // Prescaler: free-runs 0..CLK_DIV-1 while enabled, holds while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Digit index advances on every tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= 2'd0;
        end else begin
            idx <= idx_nxt;
        end
    end

    // Double buffer: loads land in pending and are promoted only at a frame boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            pend_vld <= 1'b0;
            active   <= '0;
        end else begin
            active <= active_nxt;
            if (wrap) begin
                pend_vld <= 1'b0;
            end else if (load) begin
                pending  <= {dp_in, bcd_in};
                pend_vld <= 1'b1;
            end
        end
    end

    // Registered outputs; polarity of sseg is applied only here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= 3'b111;
            sseg       <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (en) begin
                an   <= an_nxt;
                sseg <= SEG_ALOW ? ~seg_hi : seg_hi;
            end else begin
                an   <= 3'b111;
                sseg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux (CLK_DIV=4, BLANK_LZ=1, SEG_ALOW=1).
// Expected {an,sseg} per digit slot are queued ahead of each frame and popped whenever an changes.
// Also checks digit/frame periods, reset, async reset, and en=0 hold behaviour.
module tb_bcd_display_mux;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] bcd_in = '0;
    logic [2:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  an;
    logic [7:0]  sseg;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    logic [10:0] sb[$];

    bcd_display_mux #(.CLK_DIV(4), .BLANK_LZ(1'b1), .SEG_ALOW(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .en         (en),
        .an         (an),
        .sseg       (sseg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Active-low glyph table {dp,g,f,e,d,c,b,a}, dp off.
    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    task automatic push_frame(input logic [11:0] b, input logic [2:0] dp);
        logic [7:0] u, t, h;
        u = glyph(b[3:0]);
        if (dp[0]) u[7] = 1'b0;
        t = glyph(b[7:4]);
        if (dp[1]) t[7] = 1'b0;
        if (b[11:8] == 4'd0 && b[7:4] == 4'd0) t = 8'hFF;
        h = glyph(b[11:8]);
        if (dp[2]) h[7] = 1'b0;
        if (b[11:8] == 4'd0) h = 8'hFF;
        sb.push_back({3'b110, u});
        sb.push_back({3'b101, t});
        sb.push_back({3'b011, h});
    endtask

    // Returns at the negedge where frame_done is seen high.
    task automatic wait_frame();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = frame_done;
        end
        tests++;
        assert (got) else begin
            fails++;
            $error("FAIL wait_frame: frame_done observed 0 expected 1 within 40 clks");
        end
    endtask

    // Monitor: pops one expectation per digit change, times digit slots and frames.
    logic [2:0] prev_an = 3'b111;
    int  cyc = 0;
    int  last_chg = 0;
    int  nchg = 0;
    int  last_fd = 0;
    bit  have_fd = 1'b0;
    bit  chk_period = 1'b0;

    always @(negedge clk) begin
        logic [10:0] e;
        cyc++;
        if (an !== prev_an) begin
            if (an !== 3'b111) begin
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_underflow: observed an=%b sseg=%h expected no digit change", an, sseg);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("digit", {21'd0, an, sseg}, {21'd0, e});
                end
                if (chk_period && nchg >= 2) check("digit_period", cyc - last_chg, 4);
                last_chg = cyc;
                nchg++;
            end else begin
                nchg = 0;
            end
        end
        prev_an = an;
        if (!chk_period || !reset_n) begin
            have_fd = 1'b0;
        end else if (frame_done) begin
            if (have_fd) check("frame_period", cyc - last_fd, 12);
            have_fd = 1'b1;
            last_fd = cyc;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_an", an, 3'b111);
        check("rst_sseg", sseg, 8'hFF);
        check("rst_fd", frame_done, 1'b0);

        // Scenario 1: blank display value 000 scanning
        push_frame(12'h000, 3'b000);
        push_frame(12'h000, 3'b000);
        chk_period = 1'b1;
        reset_n = 1'b1;
        en = 1'b1;
        wait_frame();
        push_frame(12'h000, 3'b000);

        // Scenario 2: mid-frame load of 047 shows from the next frame
        wait_frame();
        repeat (2) @(negedge clk);
        bcd_in = 12'h047; dp_in = 3'b000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_frame(12'h047, 3'b000);

        // Scenario 3: two loads in one frame, the last one wins
        wait_frame();
        @(negedge clk);
        bcd_in = 12'h305; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        bcd_in = 12'h999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_frame(12'h999, 3'b000);

        // Scenario 4: load coincides with the wrap and goes straight to active
        wait_frame();
        push_frame(12'h120, 3'b000);
        repeat (11) @(negedge clk);
        bcd_in = 12'h120; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("wrap_load_fd", frame_done, 1'b1);

        // Scenario 5: invalid tens digit, dp on all digits
        @(negedge clk);
        bcd_in = 12'h0A0; dp_in = 3'b111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        push_frame(12'h0A0, 3'b111);
        wait_frame();
        push_frame(12'h0A0, 3'b111);

        // Scenario 6: asynchronous reset mid-frame
        wait_frame();
        repeat (5) @(negedge clk);
        chk_period = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_an", an, 3'b111);
        check("arst_sseg", sseg, 8'hFF);
        check("arst_fd", frame_done, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        push_frame(12'h000, 3'b000);
        push_frame(12'h000, 3'b000);
        reset_n = 1'b1;
        chk_period = 1'b1;
        wait_frame();
        repeat (10) @(negedge clk);

        // en=0: dark display, held scan position, load still captured
        chk_period = 1'b0;
        en = 1'b0;
        bcd_in = 12'h123; dp_in = 3'b000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("sb_drained", sb.size(), 0);
        check("en0_an", an, 3'b111);
        check("en0_sseg", sseg, 8'hFF);
        repeat (5) @(negedge clk);
        check("en0_hold_an", an, 3'b111);
        sb.push_back({3'b011, 8'hFF});
        push_frame(12'h123, 3'b000);
        en = 1'b1;
        chk_period = 1'b1;
        wait_frame();
        en = 1'b0;
        @(negedge clk);
        check("sb_leftover", sb.size(), 2);
        check("en0_final_an", an, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
